ray_dispatch_scheduler: RTL and testbench

//   Frame-level sequencer between the ray generator and a bank of NUM_TRACERS tracer units.

---
 rtl/ray_dispatch_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ray_dispatch_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler
//   Frame-level sequencer between the ray generator and a bank of tracer units.
//   On an accepted start it pulls exactly image_width*image_height rays from the
//   generator, tags each with its raster-order pixel index, offers each one to a
//   tracer chosen by round-robin arbitration, counts rays in flight, and pulses
//   frame_done once every issued ray has been retired.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   start                 frame start, sampled only while idle
//   image_width/height    frame dimensions, latched on accepted start
//   gen_valid/gen_ready   generator handshake
//   gen_dir_x/y/z         ray direction from the generator
//   tr_ready/tr_valid     per-tracer handshake, tr_valid is one-hot or zero
//   tr_dir_x/y/z          direction of the offered ray (hold register)
//   tr_pixel              pixel index of the offered ray
//   tr_done               per-tracer one-cycle retire pulse
//   busy                  high whenever not idle
//   frame_done            one-cycle end-of-frame pulse
//   stall_cycles          only with STALL_COUNT_EN defined: count of cycles a
//                         held ray waited for a tracer, saturating
//
// Build option: define STALL_COUNT_EN to add the stall_cycles output.

module ray_dispatch_scheduler #(
  parameter int NUM_TRACERS = 4,
  parameter int CNT_W       = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [12:0]            image_width,
  input  logic [12:0]            image_height,
  input  logic                   gen_valid,
  output logic                   gen_ready,
  input  logic [31:0]            gen_dir_x,
  input  logic [31:0]            gen_dir_y,
  input  logic [31:0]            gen_dir_z,
  input  logic [NUM_TRACERS-1:0] tr_ready,
  output logic [NUM_TRACERS-1:0] tr_valid,
  output logic [31:0]            tr_dir_x,
  output logic [31:0]            tr_dir_y,
  output logic [31:0]            tr_dir_z,
  output logic [CNT_W-1:0]       tr_pixel,
  input  logic [NUM_TRACERS-1:0] tr_done,
  output logic                   busy,
  output logic                   frame_done
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int IDX_W = (NUM_TRACERS > 1) ? $clog2(NUM_TRACERS) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] total_reg, issued_reg, outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] accepted, done_cnt, frame_total, in_flight;
  logic             hold_valid_reg;
  logic [IDX_W-1:0] rr_reg, grant_idx;
  logic [NUM_TRACERS-1:0] grant;
  logic             grant_any, transfer, accept_gen, frame_start;

  assign frame_total = CNT_W'(image_width) * CNT_W'(image_height);
  // Rays already taken from the generator this frame, including the held one.
  assign accepted    = issued_reg + CNT_W'(hold_valid_reg);
  assign gen_ready   = (state_reg == DISPATCH) && !hold_valid_reg && (accepted < total_reg);
  assign accept_gen  = gen_valid && gen_ready;
  assign frame_start = (state_reg == IDLE) && start;
  assign busy        = (state_reg != IDLE);
  assign frame_done  = (state_reg == DONE);

  // Round-robin search: first ready tracer at or above rr_reg, wrapping.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    sum       = '0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_TRACERS; k++) begin
      sum = {1'b0, rr_reg} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_TRACERS))
        sum = sum - (IDX_W+1)'(NUM_TRACERS);
      idx = sum[IDX_W-1:0];
      if (!grant_any && tr_ready[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TRACERS; gi++) begin : g_valid
    assign tr_valid[gi] = (state_reg == DISPATCH) && hold_valid_reg && grant[gi];
  end

  assign transfer = (state_reg == DISPATCH) && hold_valid_reg && grant_any;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_TRACERS; i++)
      done_cnt = done_cnt + CNT_W'(tr_done[i]);
  end

  // Issue and retire in the same cycle net out; stray retires never underflow.
  assign in_flight = outstanding_reg + CNT_W'(transfer);
  assign outstanding_next = (done_cnt >= in_flight) ? '0 : (in_flight - done_cnt);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = (frame_total == '0) ? DONE : DISPATCH;
      DISPATCH: if (transfer && (issued_reg + CNT_W'(1) == total_reg)) state_next = DRAIN;
      DRAIN:    if (outstanding_next == '0) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      total_reg       <= '0;
      issued_reg      <= '0;
      outstanding_reg <= '0;
      hold_valid_reg  <= 1'b0;
      rr_reg          <= '0;
      tr_dir_x        <= '0;
      tr_dir_y        <= '0;
      tr_dir_z        <= '0;
      tr_pixel        <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      if (frame_start) begin
        total_reg  <= frame_total;
        issued_reg <= '0;
      end
      // accept needs an empty hold, transfer a full one: never both at once
      if (accept_gen) begin
        hold_valid_reg <= 1'b1;
        tr_dir_x       <= gen_dir_x;
        tr_dir_y       <= gen_dir_y;
        tr_dir_z       <= gen_dir_z;
        tr_pixel       <= accepted;
      end else if (transfer) begin
        hold_valid_reg <= 1'b0;
        issued_reg     <= issued_reg + CNT_W'(1);
        rr_reg         <= (grant_idx == IDX_W'(NUM_TRACERS-1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset || frame_start)
      stall_reg <= '0;
    else if ((state_reg == DISPATCH) && hold_valid_reg && !transfer && (stall_reg != '1))
      stall_reg <= stall_reg + 32'd1;
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Testbench for ray_dispatch_scheduler: a cycle model tracks the expected
// state, handshakes and in-flight count; accepted generator rays are queued
// and compared against the tracer-side offer when a transfer occurs.
module tb_ray_dispatch_scheduler;
  localparam int N  = 4;
  localparam int CW = 26;

  logic          clk = 1'b0;
  logic          reset, start, gen_valid, gen_ready, busy, frame_done;
  logic [12:0]   image_width, image_height;
  logic [31:0]   gen_dir_x, gen_dir_y, gen_dir_z, tr_dir_x, tr_dir_y, tr_dir_z;
  logic [N-1:0]  tr_ready, tr_valid, tr_done;
  logic [CW-1:0] tr_pixel;
`ifdef STALL_COUNT_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  ray_dispatch_scheduler #(.NUM_TRACERS(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .image_width(image_width), .image_height(image_height),
    .gen_valid(gen_valid), .gen_ready(gen_ready),
    .gen_dir_x(gen_dir_x), .gen_dir_y(gen_dir_y), .gen_dir_z(gen_dir_z),
    .tr_ready(tr_ready), .tr_valid(tr_valid),
    .tr_dir_x(tr_dir_x), .tr_dir_y(tr_dir_y), .tr_dir_z(tr_dir_z),
    .tr_pixel(tr_pixel), .tr_done(tr_done),
    .busy(busy), .frame_done(frame_done)
`ifdef STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct packed {
    logic [95:0]   dir;
    logic [CW-1:0] pix;
  } ray_t;

  typedef enum {M_IDLE, M_DISP, M_DRAIN, M_DONE} mstate_t;

  ray_t    sb_q[$];
  int      vectors = 0, miscompares = 0;
  mstate_t m = M_IDLE;
  int      total_m = 0, acc_m = 0, iss_m = 0, out_m = 0, rr_m = 0, gen_idx = 0, stall_m = 0;
  int      frames_m = 0, fd_seen = 0;
  logic [N-1:0] pipe [4];
  logic [N-1:0] xfer_vec = '0, ready_pat = '1, extra_done = '0;
  int      echo_delay = 3, ready_mode = 0, gv_mode = 0, hold_off = 0;
  bit      start_noise = 0, start_req = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] grant_of(input logic [N-1:0] rdy, input int rr);
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (rdy[i]) return one << i;
    end
    return '0;
  endfunction

  // Drive inputs for the coming cycle (just after the active edge).
  task automatic prep();
    pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = xfer_vec;
    xfer_vec  = '0;
    tr_done   = pipe[echo_delay-1] | extra_done;
    gen_valid = (gv_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    gen_dir_x = 32'h1000_0000 + 32'(gen_idx);
    gen_dir_y = 32'h2000_0000 ^ (32'(gen_idx) * 32'd3);
    gen_dir_z = {16'(gen_idx), 16'hbeef};
    if (hold_off > 0) begin
      tr_ready = '0;
      hold_off--;
    end else begin
      tr_ready = (ready_mode != 0) ? N'($urandom) : ready_pat;
    end
    start = start_req || (start_noise && (m != M_IDLE) && ($urandom_range(0, 3) == 0));
    start_req = 0;
  endtask

  // Compare outputs against the model, then advance the model one cycle.
  task automatic observe();
    logic [N-1:0] exp_tv;
    logic         exp_gr;
    int           pops, sum, out_next, idx;
    ray_t         r;
    exp_gr = (m == M_DISP) && (sb_q.size() == 0) && (acc_m < total_m);
    exp_tv = (m == M_DISP && sb_q.size() > 0) ? grant_of(tr_ready, rr_m) : '0;
    check_val("gen_ready", gen_ready, exp_gr);
    check_val("tr_valid", tr_valid, exp_tv);
    check_val("frame_done", frame_done, m == M_DONE);
    check_val("busy", busy, m != M_IDLE);
`ifdef STALL_COUNT_EN
    check_val("stall_cycles", stall_cycles, stall_m);
`endif
    if (frame_done) fd_seen++;
    pops     = $countones(tr_done);
    sum      = out_m + ((exp_tv != 0) ? 1 : 0);
    out_next = (pops >= sum) ? 0 : sum - pops;
    case (m)
      M_IDLE: if (start) begin
        total_m = int'(image_width) * int'(image_height);
        acc_m = 0; iss_m = 0; stall_m = 0;
        m = (total_m == 0) ? M_DONE : M_DISP;
        $display("frame start w=%0d h=%0d", image_width, image_height);
      end
      M_DISP: begin
        if (exp_tv != 0) begin
          r = sb_q.pop_front();
          check_val("tr_pixel", tr_pixel, r.pix);
          check_val("tr_dir", {tr_dir_x, tr_dir_y, tr_dir_z}, r.dir);
          idx = 0;
          for (int i = 0; i < N; i++) if (exp_tv[i]) idx = i;
          $display("xfer tracer=%0d pixel=%0d", idx, tr_pixel);
          xfer_vec = exp_tv;
          iss_m++;
          rr_m = (idx + 1) % N;
          if (iss_m == total_m) m = M_DRAIN;
        end else if (sb_q.size() > 0) begin
          stall_m++;
        end
        if (gen_valid && exp_gr) begin
          r.dir = {gen_dir_x, gen_dir_y, gen_dir_z};
          r.pix = CW'(acc_m);
          sb_q.push_back(r);
          acc_m++;
          gen_idx++;
        end
      end
      M_DRAIN: if (out_next == 0) m = M_DONE;
      M_DONE: begin
        m = M_IDLE;
        frames_m++;
      end
      default: m = M_IDLE;
    endcase
    out_m = out_next;
  endtask

  task automatic tick();
    prep();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input int budget);
    int n;
    image_width  = 13'(w);
    image_height = 13'(h);
    start_req    = 1;
    tick();
    n = 0;
    while (m != M_IDLE && n < budget) begin
      tick();
      n++;
    end
    check_val("frame_timeout", m == M_IDLE, 1'b1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    reset = 1; start = 0; gen_valid = 0; tr_ready = '0; tr_done = '0;
    image_width = '0; image_height = '0;
    gen_dir_x = '0; gen_dir_y = '0; gen_dir_z = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check_val("rst_pixel", tr_pixel, 0);
    check_val("rst_dir", {tr_dir_x, tr_dir_y, tr_dir_z}, 0);
    tick();

    // 4x2 frame, all tracers ready, 3-cycle retire echo
    run_frame(4, 2, 200);
    // empty frame
    run_frame(0, 5, 20);
    // single ready tracer, then wrap from rr=3 across 4'b1001
    ready_pat = 4'b0100;
    run_frame(3, 1, 100);
    ready_pat = 4'b1001;
    run_frame(2, 1, 100);
    // surplus generator data, retire coinciding with issue
    ready_pat = '1; echo_delay = 2;
    run_frame(3, 2, 200);
    // random handshakes with stray start pulses while busy
    ready_mode = 1; gv_mode = 1; start_noise = 1;
    run_frame(5, 3, 600);
    ready_mode = 0; gv_mode = 0; start_noise = 0; echo_delay = 3;
    // stray retires while idle must not underflow the in-flight count
    extra_done = 4'b1011;
    tick();
    extra_done = '0;
    run_frame(1, 1, 100);
`ifdef STALL_COUNT_EN
    hold_off = 12;
    run_frame(1, 1, 100);
    check_val("stall_total", stall_cycles, 32'd10);
`endif
    // reset while a ray is held
    image_width = 13'd4; image_height = 13'd4; start_req = 1;
    tick();
    tr_ready = '0;
    ready_pat = '0;
    for (int n = 0; n < 20 && sb_q.size() == 0; n++) tick();
    check_val("hold_before_reset", sb_q.size() > 0, 1'b1);
    reset = 1;
    prep();
    @(posedge clk);
    #1 reset = 0;
    m = M_IDLE; sb_q.delete(); out_m = 0; rr_m = 0; xfer_vec = '0;
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    ready_pat = '1;
    check_val("rst_mid_pixel", tr_pixel, 0);
    tick();
    tick();
    run_frame(2, 2, 100);
    check_val("frame_done_count", fd_seen, frames_m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
